// File: rtl/regfile_wb_arbiter.sv
// Generic FIFO used for buffering LU results.
// Latency: a pushed entry is visible at pop_dat one cycle after the push.
// Backpressure: full blocks pushes; push and pop may happen in the same cycle.
module regfile_wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// Merges pipeline WB and long-latency-unit results onto the single RF write port.
// Latency: 1 cycle from selection to rf_we/rf_rd/rf_wdata; pending clears one edge later.
// Backpressure: pipeline never stalls; lu_ready drops while the LU FIFO is full.
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_wb_valid,
    input  logic [4:0]      pipe_wb_rd,
    input  logic [XLEN-1:0] pipe_wb_data,
    input  logic            lu_valid,
    output logic            lu_ready,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    input  logic            issue_lu_valid,
    input  logic [4:0]      issue_lu_rd,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] pending
);
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } lu_beat_t;

    lu_beat_t        lu_in;
    lu_beat_t        fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic            lu_acc;
    logic            pipe_sel;
    logic            lu_bypass;

    logic            sel_vld;
    logic            sel_lu;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    logic            rf_lu;
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    assign lu_in     = '{rd: lu_rd, data: lu_data};
    assign lu_ready  = !fifo_full;
    assign lu_acc    = lu_valid && lu_ready;
    assign pipe_sel  = pipe_wb_valid && (pipe_wb_rd != 5'd0);
    assign fifo_pop  = !pipe_sel && !fifo_empty;
    assign lu_bypass = !pipe_sel && fifo_empty && lu_acc;
    assign fifo_push = lu_acc && !lu_bypass;

    regfile_wb_fifo #(
        .W     ($bits(lu_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_lu_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (lu_in),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        sel_vld  = 1'b0;
        sel_lu   = 1'b0;
        sel_rd   = 5'd0;
        sel_data = '0;
        if (pipe_sel) begin
            sel_vld  = 1'b1;
            sel_rd   = pipe_wb_rd;
            sel_data = pipe_wb_data;
        end else if (fifo_pop) begin
            sel_vld  = 1'b1;
            sel_lu   = 1'b1;
            sel_rd   = fifo_head.rd;
            sel_data = fifo_head.data;
        end else if (lu_bypass) begin
            sel_vld  = 1'b1;
            sel_lu   = 1'b1;
            sel_rd   = lu_rd;
            sel_data = lu_data;
        end
    end

    // LU-origin writes release their scoreboard bit as the RF captures them; a new issue wins.
    always_comb begin
        pend_d = pend_q;
        if (rf_we && rf_lu)
            pend_d[rf_rd] = 1'b0;
        if (issue_lu_valid && (issue_lu_rd != 5'd0))
            pend_d[issue_lu_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= 5'd0;
            rf_wdata <= '0;
            rf_lu    <= 1'b0;
            pend_q   <= '0;
        end else begin
            rf_we  <= sel_vld && (sel_rd != 5'd0);
            rf_lu  <= sel_lu;
            pend_q <= pend_d;
            if (sel_vld) begin
                rf_rd    <= sel_rd;
                rf_wdata <= sel_data;
            end
        end
    end

    assign pending  = pend_q;
    assign rs1_busy = pend_q[chk_rs1];
    assign rs2_busy = pend_q[chk_rs2];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_regfile_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            pipe_wb_valid;
    logic [4:0]      pipe_wb_rd;
    logic [XLEN-1:0] pipe_wb_data;
    logic            lu_valid;
    logic            lu_ready;
    logic [4:0]      lu_rd;
    logic [XLEN-1:0] lu_data;
    logic            issue_lu_valid;
    logic [4:0]      issue_lu_rd;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] pending;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .issue_lu_valid(issue_lu_valid), .issue_lu_rd(issue_lu_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .pending(pending)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: LU FIFO as a queue, scoreboard as a bit array, the expected RF port.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } beat_t;

    beat_t       q[$];
    bit          pend[NREG];
    bit          e_we;
    bit          e_lu;
    logic [4:0]  e_rd;
    logic [31:0] e_data;

    function automatic logic [NREG-1:0] pend_vec();
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) v[i] = pend[i];
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
        e_we = 1'b0; e_lu = 1'b0; e_rd = 5'd0; e_data = 32'd0;
    endtask

    task automatic idle();
        pipe_wb_valid = 1'b0; pipe_wb_rd = 5'd0; pipe_wb_data = '0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = '0;
        issue_lu_valid = 1'b0; issue_lu_rd = 5'd0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    endtask

    // One clock: check combinational outputs, advance the model, then check registered outputs.
    task automatic cycle();
        bit          sel;
        bit          sel_lu;
        bit          acc;
        logic [4:0]  srd;
        logic [31:0] sdat;
        beat_t       b;
        #1;
        if (pipe_wb_valid && pipe_wb_rd != 5'd0)
            assert (!pend[pipe_wb_rd]) else $error("stimulus writes a pending register");
        chk("lu_ready", lu_ready, q.size() < DEPTH);
        chk("rs1_busy", rs1_busy, pend[chk_rs1]);
        chk("rs2_busy", rs2_busy, pend[chk_rs2]);
        acc = lu_valid && (q.size() < DEPTH);
        sel = 0; sel_lu = 0; srd = 5'd0; sdat = 32'd0;
        if (pipe_wb_valid && pipe_wb_rd != 5'd0) begin
            sel = 1; srd = pipe_wb_rd; sdat = pipe_wb_data;
        end else if (q.size() > 0) begin
            b = q.pop_front();
            sel = 1; sel_lu = 1; srd = b.rd; sdat = b.data;
        end else if (acc) begin
            sel = 1; sel_lu = 1; srd = lu_rd; sdat = lu_data;
            acc = 0;
        end
        if (acc) q.push_back('{lu_rd, lu_data});
        if (e_we && e_lu) pend[e_rd] = 1'b0;
        if (issue_lu_valid && issue_lu_rd != 5'd0) pend[issue_lu_rd] = 1'b1;
        e_we = sel && (srd != 5'd0);
        e_lu = sel_lu;
        if (sel) begin e_rd = srd; e_data = sdat; end
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, e_we);
        if (e_we) begin
            chk("rf_rd", rf_rd, e_rd);
            chk("rf_wdata", rf_wdata, e_data);
        end
        chk("pending", pending, pend_vec());
    endtask

    task automatic issue(input logic [4:0] rd);
        idle(); issue_lu_valid = 1'b1; issue_lu_rd = rd; cycle(); idle();
    endtask

    task automatic lu_send(input logic [4:0] rd, input logic [31:0] d);
        idle(); lu_valid = 1'b1; lu_rd = rd; lu_data = d; cycle(); idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rf_we"}, rf_we, 1'b0);
        chk({tag, "_rf_rd"}, rf_rd, 5'd0);
        chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
        chk({tag, "_pending"}, pending, '0);
        chk({tag, "_lu_ready"}, lu_ready, 1'b1);
    endtask

    int           outs[$];
    logic [4:0]   lu_list[3];
    int           idx;
    bit           acc_pred;
    logic [4:0]   r;

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: plain pipeline write
        pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd5; pipe_wb_data = 32'hDEADBEEF;
        cycle();
        chk("t1_we", rf_we, 1'b1);
        chk("t1_data", rf_wdata, 32'hDEADBEEF);
        idle();

        // 2: scoreboard set, LU bypass, clear one edge after the write is presented
        issue(5'd7);
        chk_rs1 = 5'd7;
        cycle();
        chk("t2_busy", rs1_busy, 1'b1);
        lu_send(5'd7, 32'h1234);
        chk("t2_rd", rf_rd, 5'd7);
        chk_rs1 = 5'd7;
        cycle();
        chk("t2_clear", pending[7], 1'b0);
        idle();

        // 3: pipeline hogs the port while LU fills the FIFO
        issue(5'd10); issue(5'd11); issue(5'd12);
        lu_list[0] = 5'd10; lu_list[1] = 5'd11; lu_list[2] = 5'd12;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i < 4) begin
                pipe_wb_valid = 1'b1; pipe_wb_rd = 5'(20 + i); pipe_wb_data = 32'(i + 100);
            end
            if (idx < 3) begin
                lu_valid = 1'b1; lu_rd = lu_list[idx]; lu_data = 32'(idx + 500);
            end
            if (i == 2) begin
                #1;
                chk("t3_held", lu_ready, 1'b0);
            end
            acc_pred = lu_valid && (q.size() < DEPTH);
            cycle();
            if (acc_pred) idx++;
            if (i == 4) chk("t3_order", rf_rd, 5'd10);
        end
        idle();

        // 4: pipe rd=0 lets a buffered entry drain; LU rd=0 is consumed silently
        issue(5'd13);
        pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd5; pipe_wb_data = 32'h1;
        lu_valid = 1'b1; lu_rd = 5'd13; lu_data = 32'hABCD;
        cycle();
        idle();
        pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd0; pipe_wb_data = 32'hFFFF;
        cycle();
        chk("t4_drain_rd", rf_rd, 5'd13);
        chk("t4_drain_data", rf_wdata, 32'hABCD);
        lu_send(5'd0, 32'h55);
        chk("t4_rd0_we", rf_we, 1'b0);
        idle(); cycle();

        // 5: set and clear of the same register in one cycle, and of different registers
        issue(5'd9);
        lu_send(5'd9, 32'h99);
        issue(5'd9);
        chk("t5_setwins", pending[9], 1'b1);
        lu_send(5'd9, 32'h98);
        idle(); cycle();
        issue(5'd4);
        lu_send(5'd4, 32'h44);
        issue(5'd3);
        chk("t5_set3", pending[3], 1'b1);
        chk("t5_clr4", pending[4], 1'b0);
        lu_send(5'd3, 32'h33);
        idle(); cycle();

        // 6: async reset with two buffered LU entries
        issue(5'd14); issue(5'd15);
        pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd1; lu_valid = 1'b1; lu_rd = 5'd14; lu_data = 32'hE;
        cycle();
        pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd2; lu_valid = 1'b1; lu_rd = 5'd15; lu_data = 32'hF;
        cycle();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic obeying the decode contract
        idle();
        for (int n = 0; n < 600; n++) begin
            pipe_wb_valid = 1'b0; issue_lu_valid = 1'b0; issue_lu_rd = 5'd0;
            if (!lu_valid) begin
                if (outs.size() > 0 && $urandom_range(0, 1) == 1) begin
                    lu_valid = 1'b1; lu_rd = 5'(outs.pop_front()); lu_data = $urandom;
                end else if ($urandom_range(0, 7) == 0) begin
                    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = $urandom;
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                r = 5'($urandom_range(1, NREG - 1));
                if (!pend[r] && !(r inside {outs})) begin
                    issue_lu_valid = 1'b1; issue_lu_rd = r;
                    outs.push_back(int'(r));
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                pipe_wb_valid = 1'b1;
                pipe_wb_rd = 5'($urandom_range(0, NREG - 1));
                pipe_wb_data = $urandom;
                if (pend[pipe_wb_rd] || (issue_lu_valid && pipe_wb_rd == issue_lu_rd)
                    || (int'(pipe_wb_rd) inside {outs}))
                    pipe_wb_rd = 5'd0;
            end
            chk_rs1 = 5'($urandom_range(0, NREG - 1));
            chk_rs2 = 5'($urandom_range(0, NREG - 1));
            acc_pred = lu_valid && (q.size() < DEPTH);
            cycle();
            if (acc_pred) lu_valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
